// File: rtl/l2_word_responder.sv
// rtl/l2_word_responder.sv - fixed-latency word responder for icache line fills
// One request in flight; the backing store is preloadable and survives reset.
module l2_word_responder #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 4096,
  parameter int LATENCY  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            l2_req_valid,
  input  logic [XLEN-1:0] l2_req_address,
  output logic            l2_req_ready,
  output logic [XLEN-1:0] l2_fetched_word,
  output logic            l2_fulfilled,
  output logic            l2_error,
  input  logic            preload_en,
  input  logic [XLEN-1:0] preload_address,
  input  logic [XLEN-1:0] preload_data
);

  localparam int DEPTH = MEM_SIZE / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LATENCY + 1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("l2_word_responder: XLEN must be 32");
  end
  if (MEM_SIZE < 4 || (MEM_SIZE % 4) != 0 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem
    $error("l2_word_responder: MEM_SIZE must be a power of two >= 4");
  end
  if (LATENCY < 1) begin : g_bad_lat
    $error("l2_word_responder: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [XLEN-3:0]    word_idx_q, word_idx_d;
  logic [XLEN-1:0]    fetched_word_q, fetched_word_d;
  logic               error_q, error_d;

  logic [XLEN-1:0]    mem [DEPTH];
  logic [XLEN-3:0]    read_idx;
  logic               read_in_range;
  logic               preload_in_range;
  logic               enter_respond;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{l2_req_address[1:0], preload_address[1:0]};

  // With LATENCY=1 the read happens on the accept edge, so it must use the live address.
  assign read_idx         = (state_q == ST_IDLE) ? l2_req_address[XLEN-1:2] : word_idx_q;
  assign read_in_range    = read_idx < (XLEN-2)'(DEPTH);
  assign preload_in_range = preload_address[XLEN-1:2] < (XLEN-2)'(DEPTH);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    word_idx_d     = word_idx_q;
    fetched_word_d = fetched_word_q;
    error_d        = error_q;
    enter_respond  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (l2_req_valid) begin
          word_idx_d = l2_req_address[XLEN-1:2];
          if (LATENCY == 1) begin
            state_d       = ST_RESPOND;
            cnt_d         = '0;
            enter_respond = 1'b1;
          end else begin
            // WAIT spans LATENCY-1 cycles; the last one reads the store.
            state_d = ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d       = ST_RESPOND;
          cnt_d         = '0;
          enter_respond = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        error_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        error_d = 1'b0;
      end
    endcase

    if (enter_respond) begin
      fetched_word_d = read_in_range ? mem[read_idx[IDX_W-1:0]] : '0;
      error_d        = ~read_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      word_idx_q     <= '0;
      fetched_word_q <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      word_idx_q     <= word_idx_d;
      fetched_word_q <= fetched_word_d;
      error_q        <= error_d;
    end
  end

  // Not reset: boot code preloads the store before releasing the requester.
  always_ff @(posedge clk) begin
    if (preload_en && preload_in_range) begin
      mem[preload_address[IDX_W+1:2]] <= preload_data;
    end
  end

  assign l2_req_ready    = (state_q == ST_IDLE);
  assign l2_fulfilled    = (state_q == ST_RESPOND);
  assign l2_error        = error_q;
  assign l2_fetched_word = fetched_word_q;

endmodule

// File: tb/tb_l2_word_responder.sv
// tb/tb_l2_word_responder.sv - scoreboard bench for l2_word_responder at LATENCY 4 and 1
module tb_l2_word_responder;

  localparam int MEM_SIZE = 4096;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [31:0] req_addr [2];
  logic [1:0]  ready;
  logic [31:0] word [2];
  logic [1:0]  fulfilled;
  logic [1:0]  err;
  logic        preload_en;
  logic [31:0] preload_addr;
  logic [31:0] preload_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_word_responder #(.XLEN(32), .MEM_SIZE(MEM_SIZE), .LATENCY(4)) dut4 (
    .clk(clk), .reset(rst[0]),
    .l2_req_valid(req_valid[0]), .l2_req_address(req_addr[0]), .l2_req_ready(ready[0]),
    .l2_fetched_word(word[0]), .l2_fulfilled(fulfilled[0]), .l2_error(err[0]),
    .preload_en(preload_en), .preload_address(preload_addr), .preload_data(preload_data)
  );

  l2_word_responder #(.XLEN(32), .MEM_SIZE(MEM_SIZE), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst[1]),
    .l2_req_valid(req_valid[1]), .l2_req_address(req_addr[1]), .l2_req_ready(ready[1]),
    .l2_fetched_word(word[1]), .l2_fulfilled(fulfilled[1]), .l2_error(err[1]),
    .preload_en(preload_en), .preload_address(preload_addr), .preload_data(preload_data)
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    if (a < MEM_SIZE) ref_mem[int'(a >> 2)] = d;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (ref_mem.exists(int'(a >> 2))) return ref_mem[int'(a >> 2)];
    return 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk); #1;
    preload_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic wait_ready(input int d, output int c);
    for (int i = 0; i < 50; i++) begin
      if (ready[d]) break;
      @(posedge clk); #1;
    end
    if (!ready[d]) chk(1'b0, "ready_timeout", {31'd0, ready[d]}, 32'd1);
    c = cyc;
  endtask

  // pk: cycle offset (0 = presentation cycle) of a preload to the same address, -1 for none.
  task automatic do_req(input int d, input logic [31:0] a, input int pk, input logic [31:0] pd,
                        input bit busy, output int pres);
    exp_t e;
    int   lat;
    int   c;
    lat = lat_of(d);
    wait_ready(d, c);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    pres = cyc;
    e.err  = (a >= MEM_SIZE);
    e.due  = pres + lat;
    if (e.err) e.data = 32'h0;
    else if (pk >= 0 && pk < lat - 1) e.data = pd;
    else e.data = model_rd(a);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (pk == 0) begin preload_en = 1'b1; preload_addr = a; preload_data = pd; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    preload_en   = 1'b0;
    if (pk == 0) model_wr(a, pd);
    for (int i = 1; i < lat; i++) begin
      req_valid[d] = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == pk) begin preload_en = 1'b1; preload_addr = a; preload_data = pd; end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      preload_en   = 1'b0;
      if (i == pk) model_wr(a, pd);
    end
  endtask

  task automatic mon_one(input int d);
    exp_t e;
    if (!fulfilled[d]) begin
      if (err[d]) chk(1'b0, "error_without_fulfilled", 32'd1, 32'd0);
      return;
    end
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk(1'b0, "unexpected_response", word[d], 32'h0);
      return;
    end
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    chk(word[d] === e.data, "resp_data", word[d], e.data);
    chk(err[d] === e.err, "resp_error", {31'd0, err[d]}, {31'd0, e.err});
    chk(cyc == e.due, "resp_cycle", cyc, e.due);
  endtask

  always @(negedge clk) begin
    mon_one(0);
    mon_one(1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, prev, c, n;
    rst = 2'b11; req_valid = 2'b00; req_addr[0] = 0; req_addr[1] = 0;
    preload_en = 1'b0; preload_addr = 0; preload_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk(ready[d] === 1'b1, "reset_ready", {31'd0, ready[d]}, 32'd1);
      chk(fulfilled[d] === 1'b0, "reset_fulfilled", {31'd0, fulfilled[d]}, 32'd0);
      chk(err[d] === 1'b0, "reset_error", {31'd0, err[d]}, 32'd0);
      chk(word[d] === 32'h0, "reset_word", word[d], 32'h0);
    end

    for (int i = 0; i < 64; i++) preload(32'h200 + 32'(4 * i), $urandom);

    preload(32'h10, 32'hDEADBEEF);
    do_req(0, 32'h10, -1, 0, 1'b0, p);
    wait_ready(0, c);
    chk(c - p - 1 == 4, "ready_low_cycles", c - p - 1, 32'd4);

    preload(32'h1010, 32'h0BAD0BAD);
    do_req(0, 32'h10, -1, 0, 1'b0, p);

    for (int i = 0; i < 8; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    for (int d = 0; d < 2; d++) begin
      for (int pass = 0; pass < 2; pass++) begin
        prev = -1;
        for (int i = 7; i >= 0; i--) begin
          do_req(d, (32'h100 + 32'(4 * i)) | (pass == 1 ? 32'h3 : 32'h0), -1, 0, 1'b0, p);
          if (prev >= 0) chk(p - prev == lat_of(d) + 1, "period", p - prev, lat_of(d) + 1);
          prev = p;
        end
      end
    end

    do_req(0, 32'h1000, -1, 0, 1'b0, p);
    do_req(0, 32'h104, -1, 0, 1'b0, p);
    do_req(1, 32'hFFFF_FFFC, -1, 0, 1'b0, p);
    do_req(1, 32'h108, -1, 0, 1'b0, p);

    preload(32'h20, 32'h1111);
    do_req(0, 32'h20, 3, 32'h2222, 1'b0, p);
    preload(32'h20, 32'h1111);
    do_req(0, 32'h20, 2, 32'h2222, 1'b0, p);
    preload(32'h24, 32'h3333);
    do_req(1, 32'h24, 0, 32'h4444, 1'b0, p);
    do_req(1, 32'h24, -1, 0, 1'b0, p);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) do_req(d, 32'h10, -1, 0, 1'b1, p);

    wait_ready(0, c);
    req_valid[0] = 1'b1; req_addr[0] = 32'h104;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    chk(ready[0] === 1'b1, "post_reset_ready", {31'd0, ready[0]}, 32'd1);
    chk(word[0] === 32'h0, "post_reset_word", word[0], 32'h0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (fulfilled[0]) n++;
    end
    chk(n == 0, "post_reset_no_response", n, 32'd0);
    @(posedge clk); #1;
    do_req(0, 32'h104, -1, 0, 1'b0, p);

    for (int i = 0; i < 60; i++) begin
      int          d, pk;
      logic [31:0] a;
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) a = $urandom | 32'h1000;
      else a = 32'h200 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      pk = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, lat_of(d) - 1)) : -1;
      if ($urandom_range(0, 3) == 0) preload(32'h200 + 32'(4 * $urandom_range(0, 63)), $urandom);
      do_req(d, a, pk, $urandom, 1'($urandom_range(0, 1)), p);
    end

    repeat (10) @(posedge clk);
    #1;
    chk(q0.size() == 0, "scoreboard0_drained", q0.size(), 32'd0);
    chk(q1.size() == 0, "scoreboard1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
